// File: rtl/um245_uart_ctrl_if.sv
// ---------------------------------------------------------------------------
// um245_uart_ctrl_if
//
// Purpose: CPU-side bus between the CPU datapath and the UM245 UART
// controller. It carries the one-cycle read/write selects, the transmit
// byte, the RX holding register and the condition/error flags.
//
// Handshake: there is no ready signal. cpu_rd and cpu_wr are single-cycle
// strobes, and the controller acts on them at the next rising clock edge.
// The CPU uses flag_di (an RX byte is valid) and flag_do (the TX holding
// register is empty) to decide when a strobe is legal. A strobe issued while
// its flag is false is ignored, and the matching sticky error flag is set.
//
// Signals:
//   cpu_rd     CPU -> ctrl  consume one RX byte this cycle
//   cpu_wr     CPU -> ctrl  load cpu_wdata into the TX holding register
//   cpu_wdata  CPU -> ctrl  byte to transmit
//   cpu_rdata  ctrl -> CPU  RX holding register
//   flag_di    ctrl -> CPU  RX byte available
//   flag_do    ctrl -> CPU  TX holding register empty
//   err_under  ctrl -> CPU  sticky: read with no RX byte
//   err_over   ctrl -> CPU  sticky: write dropped because TX was full
// Modports: master = CPU side, slave = controller side.
// ---------------------------------------------------------------------------
interface um245_uart_ctrl_if;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       flag_di;
    logic       flag_do;
    logic       err_under;
    logic       err_over;

    modport master (
        output cpu_rd, cpu_wr, cpu_wdata,
        input  cpu_rdata, flag_di, flag_do, err_under, err_over
    );

    modport slave (
        input  cpu_rd, cpu_wr, cpu_wdata,
        output cpu_rdata, flag_di, flag_do, err_under, err_over
    );
endinterface

// File: rtl/um245_uart_ctrl.sv
// ---------------------------------------------------------------------------
// um245_uart_ctrl
//
// Purpose: connects the CPU "uart" bus device to a UM245R/FT245-style
// parallel FIFO UART. One-byte RX and TX holding registers let every CPU
// read or write finish in a single clock. A small FSM shares the
// bidirectional device data bus between RX refills and TX drains, using
// round-robin arbitration when both sides want the bus.
//
// Ports:
//   clk        system clock, rising edge
//   _mr        asynchronous active-low master reset
//   cpu        CPU bus (um245_uart_ctrl_if.slave)
//   _rxf       device: low = RX data present (asynchronous)
//   _txe       device: low = TX space available (asynchronous)
//   _rd        device read strobe, active low
//   wr         device write strobe, active high (device latches on fall)
//   dev_din    device data bus input
//   dev_dout   device data bus output
//   dev_oe     1 = drive dev_dout onto the device bus
//   fsm_state  current sequencer state (debug visibility)
// ---------------------------------------------------------------------------
module um245_uart_ctrl #(
    parameter int RD_PULSE_CYC = 4,
    parameter int WR_PULSE_CYC = 3,
    parameter int RECOVERY_CYC = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 _mr,
    um245_uart_ctrl_if.slave     cpu,
    input  logic                 _rxf,
    input  logic                 _txe,
    output logic                 _rd,
    output logic                 wr,
    input  logic [7:0]           dev_din,
    output logic [7:0]           dev_dout,
    output logic                 dev_oe,
    output logic [2:0]           fsm_state
);

    localparam int MAX_RW  = (RD_PULSE_CYC > WR_PULSE_CYC) ? RD_PULSE_CYC : WR_PULSE_CYC;
    localparam int MAX_CYC = (MAX_RW > RECOVERY_CYC) ? MAX_RW : RECOVERY_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_STROBE  = 3'd1,
        RD_RECOVER = 3'd2,
        WR_SETUP   = 3'd3,
        WR_STROBE  = 3'd4,
        WR_RECOVER = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] rxf_sync, txe_sync;
    logic                   rxf_s, txe_s;

    logic [CNT_W-1:0] cnt, cnt_load;
    logic             cnt_zero;

    logic       rx_valid, tx_valid;
    logic [7:0] rx_data, tx_data;
    logic       err_under_q, err_over_q;
    logic       last_grant_tx;

    logic rx_req, tx_req, grant_rx, grant_tx;
    logic rd_capture, tx_done;

    // ------------------------------------------------------------------
    // Synchronisers. They reset to 1, the inactive level of both device
    // flags, so that nothing is requested while the chain refills.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            rxf_sync <= '1;
            txe_sync <= '1;
        end else begin
            rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], _rxf};
            txe_sync <= {txe_sync[SYNC_STAGES-2:0], _txe};
        end
    end

    assign rxf_s = rxf_sync[SYNC_STAGES-1];
    assign txe_s = txe_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Requests and round-robin arbitration. The bus is granted only from
    // IDLE. When both sides ask at once, the side that did not win last
    // time gets the bus.
    // ------------------------------------------------------------------
    assign rx_req   = !rx_valid && !rxf_s;
    assign tx_req   = tx_valid && !txe_s;
    assign grant_rx = rx_req && (!tx_req || last_grant_tx);
    assign grant_tx = tx_req && (!rx_req || !last_grant_tx);

    assign cnt_zero   = (cnt == '0);
    assign rd_capture = (state == RD_STROBE) && cnt_zero;
    assign tx_done    = (state == WR_STROBE) && cnt_zero;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_rx) begin
                    state_nxt = RD_STROBE;
                end else if (grant_tx) begin
                    state_nxt = WR_SETUP;
                end
            end
            RD_STROBE:  if (cnt_zero) state_nxt = RD_RECOVER;
            RD_RECOVER: if (cnt_zero) state_nxt = IDLE;
            WR_SETUP:   state_nxt = WR_STROBE;
            WR_STROBE:  if (cnt_zero) state_nxt = WR_RECOVER;
            WR_RECOVER: if (cnt_zero) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The strobes are decoded straight from the state
    // register, so an asynchronous reset releases them without waiting
    // for a clock edge. dev_oe stays high through WR_RECOVER to give the
    // device hold time after wr falls.
    // ------------------------------------------------------------------
    always_comb begin
        _rd    = 1'b1;
        wr     = 1'b0;
        dev_oe = 1'b0;
        case (state)
            RD_STROBE:  _rd = 1'b0;
            WR_SETUP:   dev_oe = 1'b1;
            WR_STROBE: begin
                dev_oe = 1'b1;
                wr     = 1'b1;
            end
            WR_RECOVER: dev_oe = 1'b1;
            default: begin
                _rd    = 1'b1;
                wr     = 1'b0;
                dev_oe = 1'b0;
            end
        endcase
    end

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Phase counter. It loads (cycles - 1) when the FSM enters a timed
    // state and counts down to zero. Zero marks the last cycle.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_load = '0;
        case (state_nxt)
            RD_STROBE:  cnt_load = CNT_W'(RD_PULSE_CYC - 1);
            RD_RECOVER: cnt_load = CNT_W'(RECOVERY_CYC - 1);
            WR_STROBE:  cnt_load = CNT_W'(WR_PULSE_CYC - 1);
            WR_RECOVER: cnt_load = CNT_W'(RECOVERY_CYC - 1);
            default:    cnt_load = '0;
        endcase
    end

    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= cnt_load;
        end else if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Grant history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            last_grant_tx <= 1'b1;
        end else if (state == IDLE) begin
            if (grant_rx) begin
                last_grant_tx <= 1'b0;
            end else if (grant_tx) begin
                last_grant_tx <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX holding register. A device capture cannot coincide with a valid
    // CPU read, because the FSM only starts a read while rx_valid is 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            rx_valid    <= 1'b0;
            rx_data     <= 8'h00;
            err_under_q <= 1'b0;
        end else begin
            if (rd_capture) begin
                rx_valid <= 1'b1;
                rx_data  <= dev_din;
            end else if (cpu.cpu_rd && rx_valid) begin
                rx_valid <= 1'b0;
            end
            if (cpu.cpu_rd && !rx_valid) begin
                err_under_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX holding register. A write that lands on the drain-exit edge
    // refills the register: the old byte has already been strobed out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            err_over_q <= 1'b0;
        end else begin
            if (cpu.cpu_wr && (!tx_valid || tx_done)) begin
                tx_valid <= 1'b1;
                tx_data  <= cpu.cpu_wdata;
            end else if (tx_done) begin
                tx_valid <= 1'b0;
            end
            if (cpu.cpu_wr && tx_valid && !tx_done) begin
                err_over_q <= 1'b1;
            end
        end
    end

    assign dev_dout      = tx_data;
    assign cpu.cpu_rdata = rx_data;
    assign cpu.flag_di   = rx_valid;
    assign cpu.flag_do   = !tx_valid;
    assign cpu.err_under = err_under_q;
    assign cpu.err_over  = err_over_q;

endmodule

// File: tb/tb_um245_uart_ctrl.sv
// Testbench for um245_uart_ctrl: a cycle table for the basic read and write
// paths, plus hand-written sequences for arbitration, error flags, the
// write-on-exit-edge case and reset in the middle of an access.
module tb_um245_uart_ctrl;

    localparam int REC = 2;

    logic       clk;
    logic       mr_n;
    logic       rxf_n, txe_n;
    logic       rd_n, wr, dev_oe;
    logic [7:0] dev_din, dev_dout;
    logic [2:0] fsm_state;

    int checks = 0;
    int errors = 0;

    um245_uart_ctrl_if cpu_bus ();

    um245_uart_ctrl dut (
        .clk       (clk),
        ._mr       (mr_n),
        .cpu       (cpu_bus),
        ._rxf      (rxf_n),
        ._txe      (txe_n),
        ._rd       (rd_n),
        .wr        (wr),
        .dev_din   (dev_din),
        .dev_dout  (dev_dout),
        .dev_oe    (dev_oe),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mr_n              = 1'b0;
        rxf_n             = 1'b1;
        txe_n             = 1'b1;
        dev_din           = 8'h00;
        cpu_bus.cpu_rd    = 1'b0;
        cpu_bus.cpu_wr    = 1'b0;
        cpu_bus.cpu_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        mr_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rxf_n, txe_n, cpu_rd, cpu_wr;
        logic [7:0] wdata, din;
        logic       e_rd_n, e_wr, e_oe, e_di, e_do;
        logic [7:0] e_rdata;
        logic       chk_dout;
        logic [7:0] e_dout;
    } vec_t;

    function automatic vec_t mk(input logic rxf, input logic txe, input logic rd, input logic wrr,
                                input logic [7:0] wd, input logic [7:0] din,
                                input logic e_rd_n, input logic e_wr, input logic e_oe,
                                input logic e_di, input logic e_do, input logic [7:0] e_rdata,
                                input logic chk, input logic [7:0] e_dout);
        vec_t v;
        v.rxf_n = rxf;  v.txe_n = txe;  v.cpu_rd = rd;  v.cpu_wr = wrr;
        v.wdata = wd;   v.din = din;
        v.e_rd_n = e_rd_n; v.e_wr = e_wr; v.e_oe = e_oe; v.e_di = e_di; v.e_do = e_do;
        v.e_rdata = e_rdata; v.chk_dout = chk; v.e_dout = e_dout;
        return v;
    endfunction

    vec_t vecs[19];

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    logic       grant_q[$];
    logic       mon_en = 1'b0;
    logic       p_rd_n, p_oe, p_wr, p_strobe, seen_strobe;
    int         gap;

    always @(negedge clk) begin
        logic strobe;
        strobe = !rd_n || wr;
        if (!mon_en) begin
            p_rd_n = 1'b1; p_oe = 1'b0; p_wr = 1'b0; p_strobe = 1'b0;
            seen_strobe = 1'b0; gap = 0;
        end else begin
            check1("t3_rd_oe_exclusive", !rd_n && dev_oe, 1'b0);
            if (strobe && !p_strobe && seen_strobe)
                check1("t3_recovery_gap_ge2", gap >= REC, 1'b1);
            if (strobe) begin
                gap = 0;
                seen_strobe = 1'b1;
            end else begin
                gap++;
            end
            if (!rd_n && p_rd_n) grant_q.push_back(1'b0);
            if (dev_oe && !p_oe) grant_q.push_back(1'b1);
            if (wr && !p_wr) begin
                check1("t3_tx_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check8("t3_tx_byte", dev_dout, exp_q.pop_front());
            end
            p_rd_n = rd_n; p_oe = dev_oe; p_wr = wr; p_strobe = strobe;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic       exp_grant[4];
        logic [7:0] wbyte;
        int         n;

        // rxf txe rd wr wdata din | rd_n wr oe di do rdata chk dout
        vecs[0]  = mk(0,1,0,0,8'h00,8'h5A, 1,0,0,0,1,8'h00, 0,8'h00);
        vecs[1]  = mk(0,1,0,0,8'h00,8'h5A, 1,0,0,0,1,8'h00, 0,8'h00);
        vecs[2]  = mk(0,1,0,0,8'h00,8'h5A, 0,0,0,0,1,8'h00, 0,8'h00);
        vecs[3]  = mk(0,1,0,0,8'h00,8'h5A, 0,0,0,0,1,8'h00, 0,8'h00);
        vecs[4]  = mk(0,1,0,0,8'h00,8'h5A, 0,0,0,0,1,8'h00, 0,8'h00);
        vecs[5]  = mk(0,1,0,0,8'h00,8'h5A, 0,0,0,0,1,8'h00, 0,8'h00);
        vecs[6]  = mk(1,1,0,0,8'h00,8'h5A, 1,0,0,1,1,8'h5A, 0,8'h00);
        vecs[7]  = mk(1,1,0,0,8'h00,8'h00, 1,0,0,1,1,8'h5A, 0,8'h00);
        vecs[8]  = mk(1,1,1,0,8'h00,8'h00, 1,0,0,0,1,8'h5A, 0,8'h00);
        vecs[9]  = mk(1,1,0,0,8'h00,8'h00, 1,0,0,0,1,8'h5A, 0,8'h00);
        vecs[10] = mk(1,0,0,1,8'hC3,8'h00, 1,0,0,0,0,8'h5A, 0,8'h00);
        vecs[11] = mk(1,0,0,0,8'h00,8'h00, 1,0,0,0,0,8'h5A, 0,8'h00);
        vecs[12] = mk(1,0,0,0,8'h00,8'h00, 1,0,1,0,0,8'h5A, 1,8'hC3);
        vecs[13] = mk(1,0,0,0,8'h00,8'h00, 1,1,1,0,0,8'h5A, 1,8'hC3);
        vecs[14] = mk(1,0,0,0,8'h00,8'h00, 1,1,1,0,0,8'h5A, 1,8'hC3);
        vecs[15] = mk(1,0,0,0,8'h00,8'h00, 1,1,1,0,0,8'h5A, 1,8'hC3);
        vecs[16] = mk(1,1,0,0,8'h00,8'h00, 1,0,1,0,1,8'h5A, 1,8'hC3);
        vecs[17] = mk(1,1,0,0,8'h00,8'h00, 1,0,1,0,1,8'h5A, 1,8'hC3);
        vecs[18] = mk(1,1,0,0,8'h00,8'h00, 1,0,0,0,1,8'h5A, 0,8'h00);

        // ---- reset state (checked while _mr is still low) ----
        mr_n = 1'b0; rxf_n = 1'b1; txe_n = 1'b1; dev_din = 8'h00;
        cpu_bus.cpu_rd = 1'b0; cpu_bus.cpu_wr = 1'b0; cpu_bus.cpu_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_rd_n", rd_n, 1'b1);
        check1("rst_wr", wr, 1'b0);
        check1("rst_oe", dev_oe, 1'b0);
        check8("rst_dout", dev_dout, 8'h00);
        check8("rst_rdata", cpu_bus.cpu_rdata, 8'h00);
        check1("rst_flag_di", cpu_bus.flag_di, 1'b0);
        check1("rst_flag_do", cpu_bus.flag_do, 1'b1);
        check1("rst_err_under", cpu_bus.err_under, 1'b0);
        check1("rst_err_over", cpu_bus.err_over, 1'b0);
        check8("rst_state_idle", {5'b0, fsm_state}, 8'h00);
        mr_n = 1'b1;
        step();

        // ---- tests 1 and 2: cycle table ----
        for (int i = 0; i < 19; i++) begin
            rxf_n = vecs[i].rxf_n;
            txe_n = vecs[i].txe_n;
            cpu_bus.cpu_rd = vecs[i].cpu_rd;
            cpu_bus.cpu_wr = vecs[i].cpu_wr;
            cpu_bus.cpu_wdata = vecs[i].wdata;
            dev_din = vecs[i].din;
            step();
            check1($sformatf("vec%0d_rd_n", i), rd_n, vecs[i].e_rd_n);
            check1($sformatf("vec%0d_wr", i), wr, vecs[i].e_wr);
            check1($sformatf("vec%0d_oe", i), dev_oe, vecs[i].e_oe);
            check1($sformatf("vec%0d_flag_di", i), cpu_bus.flag_di, vecs[i].e_di);
            check1($sformatf("vec%0d_flag_do", i), cpu_bus.flag_do, vecs[i].e_do);
            check8($sformatf("vec%0d_rdata", i), cpu_bus.cpu_rdata, vecs[i].e_rdata);
            if (vecs[i].chk_dout)
                check8($sformatf("vec%0d_dout", i), dev_dout, vecs[i].e_dout);
        end
        cpu_bus.cpu_rd = 1'b0;
        cpu_bus.cpu_wr = 1'b0;

        // ---- test 3: contention, round-robin, bus exclusion ----
        do_reset();
        exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
        rxf_n = 1'b0; txe_n = 1'b0; dev_din = 8'h3C;
        wbyte = 8'h80;
        mon_en = 1'b1;
        for (int c = 0; c < 300 && grant_q.size() < 4; c++) begin
            cpu_bus.cpu_rd = cpu_bus.flag_di;
            cpu_bus.cpu_wr = cpu_bus.flag_do;
            if (cpu_bus.flag_di) check8("t3_rx_byte", cpu_bus.cpu_rdata, 8'h3C);
            if (cpu_bus.flag_do) begin
                cpu_bus.cpu_wdata = wbyte;
                exp_q.push_back(wbyte);
                wbyte = wbyte + 8'h01;
            end
            step();
        end
        cpu_bus.cpu_rd = 1'b0;
        cpu_bus.cpu_wr = 1'b0;
        repeat (12) step();
        mon_en = 1'b0;
        check1("t3_grant_count", grant_q.size() >= 4, 1'b1);
        for (int k = 0; k < 4; k++)
            if (k < grant_q.size()) check1($sformatf("t3_grant%0d", k), grant_q[k], exp_grant[k]);
        check1("t3_no_err_under", cpu_bus.err_under, 1'b0);
        check1("t3_no_err_over", cpu_bus.err_over, 1'b0);
        exp_q.delete();

        // ---- test 4: underrun and overrun ----
        do_reset();
        step();
        cpu_bus.cpu_rd = 1'b1;
        step();
        cpu_bus.cpu_rd = 1'b0;
        check1("t4_err_under", cpu_bus.err_under, 1'b1);
        check8("t4_rdata_kept", cpu_bus.cpu_rdata, 8'h00);
        check1("t4_flag_di", cpu_bus.flag_di, 1'b0);
        check1("t4_err_over_clear", cpu_bus.err_over, 1'b0);
        cpu_bus.cpu_wr = 1'b1; cpu_bus.cpu_wdata = 8'hAA;
        step();
        cpu_bus.cpu_wdata = 8'h55;
        step();
        cpu_bus.cpu_wr = 1'b0;
        check1("t4_err_over", cpu_bus.err_over, 1'b1);
        check1("t4_flag_do_full", cpu_bus.flag_do, 1'b0);
        txe_n = 1'b0;
        n = 0;
        while (!wr && n < 20) begin step(); n++; end
        check1("t4_wr_seen", wr, 1'b1);
        check8("t4_first_byte_kept", dev_dout, 8'hAA);
        check1("t4_err_under_sticky", cpu_bus.err_under, 1'b1);

        // ---- test 5: write on the WR_STROBE exit edge ----
        do_reset();
        txe_n = 1'b0;
        repeat (3) step();
        cpu_bus.cpu_wr = 1'b1; cpu_bus.cpu_wdata = 8'h22;
        step();
        cpu_bus.cpu_wr = 1'b0;
        check1("t5_idle_wr", wr, 1'b0);
        step();
        check1("t5_setup_wr", wr, 1'b0);
        check1("t5_setup_oe", dev_oe, 1'b1);
        step();
        check1("t5_strobe_wr", wr, 1'b1);
        check8("t5_strobe_dout", dev_dout, 8'h22);
        repeat (2) step();
        check1("t5_strobe_last_wr", wr, 1'b1);
        cpu_bus.cpu_wr = 1'b1; cpu_bus.cpu_wdata = 8'h11;
        step();
        cpu_bus.cpu_wr = 1'b0;
        check1("t5_exit_wr", wr, 1'b0);
        check1("t5_flag_do_stays_full", cpu_bus.flag_do, 1'b0);
        check1("t5_no_err_over", cpu_bus.err_over, 1'b0);
        n = 0;
        while (!wr && n < 20) begin step(); n++; end
        check1("t5_second_wr_seen", wr, 1'b1);
        check8("t5_second_dout", dev_dout, 8'h11);
        n = 0;
        while (!cpu_bus.flag_do && n < 20) begin step(); n++; end
        check1("t5_drained", cpu_bus.flag_do, 1'b1);
        check1("t5_no_err_over_end", cpu_bus.err_over, 1'b0);

        // ---- test 6: reset in the middle of RD_STROBE ----
        do_reset();
        rxf_n = 1'b0; dev_din = 8'h99;
        n = 0;
        while (rd_n && n < 20) begin step(); n++; end
        check1("t6_rd_low", rd_n, 1'b0);
        step();
        #2;
        mr_n = 1'b0;
        #1;
        check1("t6_async_rd_release", rd_n, 1'b1);
        check1("t6_async_flag_di", cpu_bus.flag_di, 1'b0);
        check1("t6_async_oe", dev_oe, 1'b0);
        check8("t6_async_state", {5'b0, fsm_state}, 8'h00);
        step();
        check1("t6_held_rd", rd_n, 1'b1);
        mr_n = 1'b1;
        dev_din = 8'h77;
        step();
        check1("t6_r0_rd", rd_n, 1'b1);
        step();
        check1("t6_r1_rd", rd_n, 1'b1);
        step();
        check1("t6_r2_rd", rd_n, 1'b0);
        repeat (3) step();
        check1("t6_r5_rd", rd_n, 1'b0);
        check1("t6_r5_di", cpu_bus.flag_di, 1'b0);
        step();
        check1("t6_r6_rd", rd_n, 1'b1);
        check1("t6_r6_di", cpu_bus.flag_di, 1'b1);
        check8("t6_r6_rdata", cpu_bus.cpu_rdata, 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
